// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the execute-stage multiply/divide sequencer.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_DONE
    } state_e;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_e;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned WD_W        = 6;
    localparam int unsigned TIMEOUT_DEF = 40;
    localparam int unsigned EXC_MULT_DEF = 4;
    localparam int unsigned EXC_DIV_DEF  = 5;
    localparam int unsigned EXC_REG_DEF  = 30;

    // rstatus code for the op that raised the exception, zero-extended to a data word
    function automatic logic [DATA_W-1:0] exc_word(op_e op, int unsigned exc_mult,
                                                   int unsigned exc_div);
        exc_word = (op == OP_MULT) ? DATA_W'(exc_mult) : DATA_W'(exc_div);
    endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// Counts cycles while enabled; flags expiry on the TIMEOUT-th enabled cycle.
module multdiv_watchdog
    import multdiv_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WD_W-1:0] count_q, count_d;

    assign expired = enable && (count_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences one mult/div operation on the shared iterative unit: latch, start pulse,
// stall until ready (or watchdog expiry), then a single-cycle writeback.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
    parameter int unsigned EXC_MULT = EXC_MULT_DEF,
    parameter int unsigned EXC_DIV  = EXC_DIV_DEF,
    parameter int unsigned EXC_REG  = EXC_REG_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_mult,
    input  logic              req_div,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [REG_W-1:0]  req_rd,
    input  logic              flush,
    output logic              ctrl_MULT,
    output logic              ctrl_DIV,
    output logic [DATA_W-1:0] data_operandA,
    output logic [DATA_W-1:0] data_operandB,
    input  logic [DATA_W-1:0] mult_result,
    input  logic              mult_exception,
    input  logic              mult_RDY,
    input  logic [DATA_W-1:0] div_result,
    input  logic              div_exception,
    input  logic              div_RDY,
    output logic              stall,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              timeout
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
    logic [REG_W-1:0]   rd_q, rd_d;
    logic               ctrl_mult_q, ctrl_mult_d;
    logic               ctrl_div_q, ctrl_div_d;
    logic               wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic               timeout_q, timeout_d;

    logic               accept;
    logic               in_busy;
    logic               unit_rdy;
    logic               unit_exc;
    logic [DATA_W-1:0]  unit_result;
    logic               wd_expired;

    assign accept      = (req_mult || req_div) && !flush;
    assign in_busy     = (state_q == ST_BUSY);
    assign unit_rdy    = (op_q == OP_MULT) ? mult_RDY       : div_RDY;
    assign unit_exc    = (op_q == OP_MULT) ? mult_exception : div_exception;
    assign unit_result = (op_q == OP_MULT) ? mult_result    : div_result;

    multdiv_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (!in_busy),
        .enable (in_busy),
        .expired(wd_expired)
    );

    // Stall covers the accept cycle too, so the pipeline never advances past an accepted op.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            ST_IDLE:  stall = accept;
            ST_START: stall = 1'b1;
            ST_BUSY:  stall = 1'b1;
            default:  stall = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rd_d        = rd_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        timeout_d   = timeout_q;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_d         = req_a;
                        b_d         = req_b;
                        rd_d        = req_rd;
                        op_d        = req_mult ? OP_MULT : OP_DIV;
                        ctrl_mult_d = req_mult;
                        ctrl_div_d  = !req_mult;
                        state_d     = ST_START;
                    end
                end
                ST_START: state_d = ST_BUSY;
                ST_BUSY: begin
                    if (unit_rdy || wd_expired) begin
                        state_d    = ST_DONE;
                        wb_valid_d = 1'b1;
                        if (unit_rdy && !unit_exc) begin
                            wb_rd_d   = rd_q;
                            wb_data_d = unit_result;
                        end else begin
                            wb_rd_d   = REG_W'(EXC_REG);
                            wb_data_d = exc_word(op_q, EXC_MULT, EXC_DIV);
                        end
                        // A real ready wins over expiry in the same cycle.
                        if (!unit_rdy) begin
                            timeout_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MULT;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            timeout_q   <= timeout_d;
        end
    end

    assign ctrl_MULT     = ctrl_mult_q;
    assign ctrl_DIV      = ctrl_div_q;
    assign data_operandA = a_q;
    assign data_operandB = b_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: reactive unit responders, a transaction-age reference model
// compared every cycle, and directed scenarios pinned with literal expectations.
module tb_multdiv_sequencer;

    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_mult = 1'b0, req_div = 1'b0, flush = 1'b0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [4:0]  req_rd = '0;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] mult_result = '0, div_result = '0;
    logic        mult_exception = 1'b0, div_exception = 1'b0;
    logic        mult_RDY = 1'b0, div_RDY = 1'b0;
    logic        stall, wb_valid, timeout;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clock = ~clock;

    multdiv_sequencer #(
        .TIMEOUT (40),
        .EXC_MULT(4),
        .EXC_DIV (5),
        .EXC_REG (30)
    ) dut (
        .clock(clock), .reset(reset),
        .req_mult(req_mult), .req_div(req_div),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .mult_result(mult_result), .mult_exception(mult_exception), .mult_RDY(mult_RDY),
        .div_result(div_result), .div_exception(div_exception), .div_RDY(div_RDY),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .timeout(timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Arithmetic the units would produce
    function automatic logic [32:0] mul_ref(logic [31:0] a, logic [31:0] b);
        logic signed [63:0] p;
        logic ovf;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        ovf = !((&p[63:31]) || (~|p[63:31]));
        return {ovf, p[31:0]};
    endfunction

    function automatic logic [32:0] div_ref(logic [31:0] a, logic [31:0] b);
        longint q;
        if (b == 0) return {1'b1, 32'hFFFF_FFFF};
        q = longint'($signed(a)) / longint'($signed(b));
        return {1'b0, q[31:0]};
    endfunction

    // Reference model: an op is "active" from the cycle after acceptance until completion;
    // m_age is 1 in the start-pulse cycle and counts up through the waiting cycles.
    bit          m_active = 0, m_done = 0, m_mult = 0, m_timeout = 0;
    int          m_age = 0;
    logic [31:0] m_a = '0, m_b = '0, m_wb_data = '0;
    logic [4:0]  m_rd = '0, m_wb_rd = '0;
    bit          m_acc, m_rdy, m_exc;
    logic [31:0] m_res;

    int          wb_count = 0, cm_count = 0, cd_count = 0;
    time         wb_time = 0;
    logic [4:0]  obs_wb_rd = '0;
    logic [31:0] obs_wb_data = '0, obs_opA_wb = '0, obs_opB_wb = '0;
    logic        obs_stall_wb = 1'b0;

    always @(negedge clock) begin
        #2;
        m_acc = !m_active && !m_done && (req_mult || req_div) && !flush;
        chk("stall",     stall,         (m_active || m_acc) ? 32'd1 : 32'd0);
        chk("ctrl_MULT", ctrl_MULT,     (m_active && m_age == 1 && m_mult)  ? 32'd1 : 32'd0);
        chk("ctrl_DIV",  ctrl_DIV,      (m_active && m_age == 1 && !m_mult) ? 32'd1 : 32'd0);
        chk("wb_valid",  wb_valid,      m_done ? 32'd1 : 32'd0);
        chk("wb_rd",     wb_rd,         m_wb_rd);
        chk("wb_data",   wb_data,       m_wb_data);
        chk("operandA",  data_operandA, m_a);
        chk("operandB",  data_operandB, m_b);
        chk("timeout",   timeout,       m_timeout ? 32'd1 : 32'd0);

        if (ctrl_MULT) cm_count++;
        if (ctrl_DIV)  cd_count++;
        if (wb_valid) begin
            wb_count++;
            wb_time      = $time - 2;
            obs_wb_rd    = wb_rd;
            obs_wb_data  = wb_data;
            obs_opA_wb   = data_operandA;
            obs_opB_wb   = data_operandB;
            obs_stall_wb = stall;
        end

        if (!reset) begin
            m_active = 0; m_done = 0; m_age = 0; m_mult = 0; m_timeout = 0;
            m_a = '0; m_b = '0; m_rd = '0; m_wb_rd = '0; m_wb_data = '0;
        end else if (flush) begin
            m_active = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (req_mult || req_div) begin
                m_active = 1; m_age = 1; m_mult = req_mult;
                m_a = req_a; m_b = req_b; m_rd = req_rd;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else begin
            m_rdy = m_mult ? mult_RDY : div_RDY;
            if (m_rdy || (m_age - 1 == TIMEOUT)) begin
                m_exc = m_rdy ? (m_mult ? mult_exception : div_exception) : 1'b1;
                m_res = m_mult ? mult_result : div_result;
                if (!m_rdy) m_timeout = 1;
                m_active = 0; m_done = 1;
                m_wb_rd   = m_exc ? 5'd30 : m_rd;
                m_wb_data = m_exc ? (m_mult ? 32'd4 : 32'd5) : m_res;
            end else begin
                m_age++;
            end
        end
    end

    // Unit responders: ready op_lat cycles after the start pulse (0 = never), optional stale
    // ready around the accept/start cycles, and random noise wherever ready must be ignored.
    int          op_lat = 1;
    bit          op_stale = 0;
    int          u_cnt [2];
    bit          u_run [2];
    bit          e_acc, e_sel, e_ctl, e_rdy;
    logic [32:0] e_ref;

    always @(negedge clock) begin
        #1;
        e_acc = !m_active && !m_done && (req_mult || req_div) && !flush && reset;
        for (int u = 0; u < 2; u++) begin
            e_sel = m_active && (m_mult == (u == 0));
            e_ctl = (u == 0) ? ctrl_MULT : ctrl_DIV;
            if (e_ctl) begin
                u_cnt[u] = 0; u_run[u] = 1;
            end else if (u_run[u]) begin
                u_cnt[u]++;
            end
            if (!e_sel) u_run[u] = 0;
            if (e_sel)
                e_rdy = (u_run[u] && op_lat != 0 && u_cnt[u] == op_lat) || (op_stale && e_ctl);
            else if (e_acc && op_stale)
                e_rdy = 1;
            else
                e_rdy = $urandom_range(0, 1) == 1;
            e_ref = (u == 0) ? mul_ref(m_a, m_b) : div_ref(m_a, m_b);
            if (!(e_rdy && e_sel && u_run[u])) e_ref = {$urandom_range(0, 1) == 1, $urandom()};
            if (u == 0) begin
                mult_RDY = e_rdy; mult_result = e_ref[31:0]; mult_exception = e_ref[32];
            end else begin
                div_RDY = e_rdy; div_result = e_ref[31:0]; div_exception = e_ref[32];
            end
        end
    end

    time issue_t;
    int  wb0, cm0, cd0;

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clock);
            req_mult = 0; req_div = 0; flush = 0;
            n++;
        end while ((m_active || m_done) && n < 200);
        if (n >= 200) chk("wait_idle_bound", 32'd1, 32'd0);
    endtask

    task automatic issue(bit mul, logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                         int lat, bit stale);
        wait_idle();
        op_lat = lat; op_stale = stale;
        req_mult = mul; req_div = !mul; req_a = a; req_b = b; req_rd = rd;
        issue_t = $time; wb0 = wb_count; cm0 = cm_count; cd0 = cd_count;
        @(negedge clock);
        req_mult = 0; req_div = 0;
    endtask

    task automatic wait_wb(string tag);
        int n = 0;
        while (wb_count == wb0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_wb_seen"}, (wb_count != wb0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] lat_cycles();
        return 32'((wb_time - issue_t) / 10);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        int wbf, cmf;
        reset = 0;
        repeat (3) @(negedge clock);
        #3;
        chk("rst_stall", stall, 32'd0);
        chk("rst_wb_valid", wb_valid, 32'd0);
        chk("rst_timeout", timeout, 32'd0);
        chk("rst_operandA", data_operandA, 32'd0);
        @(negedge clock);
        reset = 1;

        issue(1, 32'd7, 32'hFFFF_FFFD, 5'd9, 17, 0);
        wait_wb("mul7");
        chk("mul7_rd", obs_wb_rd, 32'd9);
        chk("mul7_data", obs_wb_data, 32'hFFFF_FFEB);
        chk("mul7_latency", lat_cycles(), 32'd19);
        chk("mul7_ctrl_mult", 32'(cm_count - cm0), 32'd1);
        chk("mul7_ctrl_div", 32'(cd_count - cd0), 32'd0);
        chk("mul7_stall_in_done", obs_stall_wb, 32'd0);

        issue(0, 32'd100, 32'd0, 5'd12, 6, 0);
        wait_wb("div0");
        chk("div0_rd", obs_wb_rd, 32'd30);
        chk("div0_data", obs_wb_data, 32'd5);
        chk("div0_ctrl_div", 32'(cd_count - cd0), 32'd1);
        chk("div0_latency", lat_cycles(), 32'd8);

        issue(1, 32'h4000_0000, 32'd4, 5'd3, 3, 0);
        wait_wb("movf");
        chk("movf_rd", obs_wb_rd, 32'd30);
        chk("movf_data", obs_wb_data, 32'd4);
        chk("movf_opA", obs_opA_wb, 32'h4000_0000);
        chk("movf_opB", obs_opB_wb, 32'd4);

        issue(1, 32'd3, 32'd5, 5'd7, 4, 1);
        wait_wb("stale");
        chk("stale_latency", lat_cycles(), 32'd6);
        chk("stale_data", obs_wb_data, 32'd15);
        chk("stale_rd", obs_wb_rd, 32'd7);

        issue(0, 32'd9, 32'd3, 5'd11, 0, 0);
        wait_wb("wdog");
        chk("wdog_latency", lat_cycles(), 32'd42);
        chk("wdog_rd", obs_wb_rd, 32'd30);
        chk("wdog_data", obs_wb_data, 32'd5);
        chk("wdog_timeout_set", timeout, 32'd1);
        issue(0, 32'd9, 32'd3, 5'd11, 2, 0);
        wait_wb("after_wdog");
        chk("after_wdog_data", obs_wb_data, 32'd3);
        chk("after_wdog_rd", obs_wb_rd, 32'd11);
        chk("timeout_sticky", timeout, 32'd1);

        issue(1, 32'd11, 32'd13, 5'd4, 10, 0);
        wbf = wb0; cmf = cm0;
        repeat (3) @(negedge clock);
        flush = 1;
        @(negedge clock);
        flush = 0;
        op_lat = 2; op_stale = 0;
        req_mult = 1; req_div = 0; req_a = 32'd6; req_b = 32'd7; req_rd = 5'd5;
        issue_t = $time;
        @(negedge clock);
        req_mult = 0;
        wait_wb("flush2");
        chk("flush2_data", obs_wb_data, 32'd42);
        chk("flush2_rd", obs_wb_rd, 32'd5);
        chk("flush2_latency", lat_cycles(), 32'd4);
        chk("flush_wb_count", 32'(wb_count - wbf), 32'd1);
        chk("flush_ctrl_mult", 32'(cm_count - cmf), 32'd2);

        issue(0, 32'd50, 32'd7, 5'd6, 20, 0);
        repeat (5) @(negedge clock);
        reset = 0;
        @(negedge clock);
        reset = 1;
        repeat (40) @(negedge clock);
        #3;
        chk("midrst_no_wb", 32'(wb_count - wb0), 32'd0);
        chk("midrst_ctrl_div", 32'(cd_count - cd0), 32'd1);
        chk("midrst_timeout_clr", timeout, 32'd0);
        chk("midrst_stall", stall, 32'd0);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            flush = ($urandom_range(0, 49) == 0);
            reset = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 2) == 0) begin
                req_mult = $urandom_range(0, 1) == 1;
                req_div  = $urandom_range(0, 1) == 1;
                req_rd   = 5'($urandom_range(0, 31));
                req_a    = $urandom();
                case ($urandom_range(0, 3))
                    0: req_b = $urandom();
                    1: req_b = '0;
                    2: begin req_a = 32'($urandom_range(0, 200)); req_b = 32'($urandom_range(1, 50)); end
                    default: begin req_a = 32'h4000_0000; req_b = 32'($urandom_range(0, 8)); end
                endcase
            end else begin
                req_mult = 0; req_div = 0;
            end
            if (!m_active && !m_done && (req_mult || req_div)) begin
                op_lat   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 25);
                op_stale = ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clock);
        req_mult = 0; req_div = 0; flush = 0; reset = 1;
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
